pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline CPU. Collects load-use hazards from ID/EX, taken branches resolved in EX and multi-cycle mul/div issue in EX. Drives a single consistent set of write-enable, flush and bubble controls to the PC, IF/ID, ID/EX and EX/MEM registers. The block owns all pipeline freeze decisions; no other block gates pipeline-register enables.

## Interface
Parameters:
- MULDIV_LAT, 8, number of cycles a mul/div occupies EX, including the issue cycle; legal range ≥ 2.
- CNT_W, 32, width of the performance counters; used only with PIPE_CTRL_PERF_EN.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_rs_addr  in  5  rs field of the instruction in ID.
- id_rt_addr  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt_addr  in  5  destination of the load in EX.
- ex_branch_taken  in  1  branch or jump in EX resolved taken.
- ex_muldiv_start  in  1  mul/div enters EX this cycle.
- pc_we  out  1  PC write enable.
- if_id_we  out  1  IF/ID write enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_we  out  1  ID/EX write enable.
- id_ex_flush  out  1  load a NOP into ID/EX.
- ex_mem_bubble  out  1  load a NOP into EX/MEM.
- busy  out  1  mul/div sequence in progress.
- stall_cycles  out  CNT_W  stall-cycle counter; present only with PIPE_CTRL_PERF_EN.
- flush_events  out  CNT_W  taken-branch flush counter; present only with PIPE_CTRL_PERF_EN.

## Operation
- Two states, RUN and MULDIV, plus a remaining-cycle counter `rem`. The state and `rem` are registered. Outputs are combinational from the state and the inputs.
- Load-use hazard condition: `ex_mem_read` is 1, `ex_rt_addr` is not 0, and `ex_rt_addr` equals `id_rs_addr`, or `id_uses_rt` is 1 and `ex_rt_addr` equals `id_rt_addr`. A load to register $0 never stalls.
- RUN state, outputs depend on inputs in this priority order:
  - Taken branch: `if_id_flush` = 1, `id_ex_flush` = 1, all write enables = 1. Any simultaneous load-use hazard is ignored.
  - `ex_muldiv_start`: `pc_we`, `if_id_we` and `id_ex_we` = 0; `ex_mem_bubble` = 1; `busy` = 1. Next state is MULDIV with `rem` = MULDIV_LAT−2.
  - Load-use hazard: `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1, `id_ex_we` = 1. This lasts one cycle only, because the load leaves EX.
  - No hazard: all write enables = 1; flushes, bubble and `busy` = 0.
- MULDIV state:
  - Same freeze outputs as the start cycle.
  - `ex_branch_taken` and the load-use inputs are ignored; ID is re-evaluated after the block returns to RUN.
  - When `rem` = 0, next state is RUN; otherwise `rem` decrements by 1.
- Reset values (while `rst` = 1): `pc_we`, `if_id_we`, `id_ex_we` = 0; `if_id_flush`, `id_ex_flush`, `ex_mem_bubble` = 1; `busy` = 0; state = RUN; `rem` = 0; counters = 0.

## Timing
- Zero-cycle latency from hazard inputs to outputs in RUN.
- A mul/div issued in cycle t freezes the pipeline for exactly MULDIV_LAT cycles, t through t+MULDIV_LAT−1. Normal operation resumes in cycle t+MULDIV_LAT.
- Back-to-back mul/div: a start in cycle t+MULDIV_LAT begins a new sequence with no gap cycle.
- Reset asserted during MULDIV: state is RUN on the first cycle after `rst` deasserts, and no residual stall remains.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - `stall_cycles` increments in every non-reset cycle with `pc_we` = 0.
  - `flush_events` increments on every honoured taken branch.
  - Both counters saturate at all-ones and clear on reset.
- PIPE_CTRL_PERF_EN undefined: the counters and their ports do not exist. Control behaviour is identical in both builds.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MULDIV);
  - REG_ZERO = 5'd0;
  - the encoded control-bundle struct shared with the stage-register blocks.
- One sub-module, `muldiv_timer`: loadable down-counter that provides `rem` and a `done` flag.

## Test plan
- Load to r5 in EX, ID reads rs = 5 → exactly one cycle with `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1, then all enables = 1.
- Load to r0 in EX, ID reads rs = 0 → no stall; `pc_we` = 1 every cycle.
- `ex_branch_taken` and a load-use hazard in the same cycle → `if_id_flush` = 1, `id_ex_flush` = 1, `pc_we` = 1; `flush_events` increments by 1.
- `ex_muldiv_start` at cycle 10 with MULDIV_LAT = 8 → `pc_we` = 0 and `busy` = 1 for cycles 10–17; `pc_we` = 1 at cycle 18; `stall_cycles` = 8.
- `rst` asserted at cycle 13 of a mul/div sequence → reset values while `rst` = 1; first cycle after deassert has `busy` = 0 and `pc_we` = 1.
- Taken branch asserted during MULDIV → ignored: no flush, and `flush_events` is unchanged.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// the register-zero index and the control bundle driven to the stage registers.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control bundle as seen by the PC and stage-register blocks.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_bubble;
        logic busy;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET    = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
                                        id_ex_we: 1'b0, id_ex_flush: 1'b1,
                                        ex_mem_bubble: 1'b1, busy: 1'b0};
    localparam ctrl_t CTRL_NORMAL   = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                        id_ex_we: 1'b1, id_ex_flush: 1'b0,
                                        ex_mem_bubble: 1'b0, busy: 1'b0};
    localparam ctrl_t CTRL_FLUSH    = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                        id_ex_we: 1'b1, id_ex_flush: 1'b1,
                                        ex_mem_bubble: 1'b0, busy: 1'b0};
    localparam ctrl_t CTRL_FREEZE   = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                        id_ex_we: 1'b0, id_ex_flush: 1'b0,
                                        ex_mem_bubble: 1'b1, busy: 1'b1};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                        id_ex_we: 1'b1, id_ex_flush: 1'b1,
                                        ex_mem_bubble: 1'b0, busy: 1'b0};

    // A load in EX whose destination feeds a source of the ID instruction.
    // Loads to $0 never create a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    endfunction

endpackage

// File: rtl/muldiv_timer.sv
// Loadable down-counter tracking the remaining mul/div freeze cycles.
module muldiv_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] rem,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign rem  = cnt;
    assign done = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating stall/flush counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal issue; branch flush, mul/div start, load-use stall
// MULDIV | mul/div occupies EX; pipeline frozen until the timer expires
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic             busy
);

    // Holds MULDIV_LAT-2: the start cycle and the final rem==0 cycle both freeze.
    localparam int REM_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
    localparam logic [REM_W-1:0] REM_LOAD = REM_W'(MULDIV_LAT - 2);

    state_t           state;
    ctrl_t            ctrl;
    logic             start_seq;
    logic             branch_flush;
    logic [REM_W-1:0] rem;
    logic             rem_done;

    // Priority decode of the control bundle; reset forces NOPs into all stages.
    always_comb begin
        ctrl         = CTRL_NORMAL;
        start_seq    = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else if (state == MULDIV) begin
            ctrl = CTRL_FREEZE;
        end else if (ex_branch_taken) begin
            ctrl         = CTRL_FLUSH;
            branch_flush = 1'b1;
        end else if (ex_muldiv_start) begin
            ctrl      = CTRL_FREEZE;
            start_seq = 1'b1;
        end else if (load_use_hazard(ex_mem_read, ex_rt_addr, id_rs_addr,
                                     id_rt_addr, id_uses_rt)) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    // State register: leave MULDIV once the remaining count reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (start_seq) state <= MULDIV;
                MULDIV:  if (rem_done)  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    muldiv_timer #(
        .W (REM_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (start_seq),
        .load_val (REM_LOAD),
        .dec      ((state == MULDIV) && (rem != '0)),
        .rem      (rem),
        .done     (rem_done)
    );

    assign pc_we         = ctrl.pc_we;
    assign if_id_we      = ctrl.if_id_we;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_we      = ctrl.id_ex_we;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign busy          = ctrl.busy;

`ifdef PIPE_CTRL_PERF_EN
    // Saturating performance counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!ctrl.pc_we && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (branch_flush && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end
`endif

endmodule
